// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive front end.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StBreak
  } rx_state_t;

  localparam int unsigned MIN_PRESCALE     = 4;
  // 48 MHz / 115200 baud
  localparam int unsigned DEFAULT_PRESCALE = 416;

endpackage

// File: rtl/rx_byte_fifo.sv
// First-word fall-through FIFO buffering received characters.
// Simultaneous push and pop both take effect, including when full.
module rx_byte_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DATA_WIDTH-1:0]    data_in,
  input  logic                     pop,
  output logic [DATA_WIDTH-1:0]    data_out,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q;
  logic [AW-1:0]         rd_ptr_q;
  logic [AW:0]           count_q;
  logic                  do_push;
  logic                  do_pop;

  always_comb begin
    full     = (count_q == (AW + 1)'(DEPTH));
    empty    = (count_q == '0);
    do_pop   = pop && !empty;
    // A pop in the same cycle frees the slot a full FIFO needs
    do_push  = push && (!full || do_pop);
    data_out = empty ? '0 : mem_q[rd_ptr_q];
    level    = count_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW + 1)'(1);
        2'b01:   count_q <= count_q - (AW + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_in;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver: input synchronizer, oversampling deframer and a byte FIFO
// presented as a stream with single-cycle framing/overrun error pulses.
module uart_rx_fifo
  import uart_rx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned PRESCALE_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [PRESCALE_WIDTH-1:0]     prescale,
  input  logic                          rxd,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          busy,
  output logic                          frame_error,
  output logic                          overrun_error
);

  localparam int unsigned PW    = PRESCALE_WIDTH;
  localparam int unsigned IDX_W = $clog2(DATA_WIDTH);

  logic                  rxd_meta_q;
  logic                  rxd_s_q;
  rx_state_t             state_q;
  logic [PW-1:0]         cnt_q;
  logic [PW-1:0]         pre_q;
  logic [IDX_W-1:0]      bit_idx_q;
  logic [DATA_WIDTH-1:0] shreg_q;
  logic                  frame_error_q;
  logic                  overrun_q;

  logic [PW-1:0]         eff_prescale;
  logic                  stop_ok;
  logic                  fifo_full;
  logic                  fifo_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxd_meta_q <= 1'b1;
      rxd_s_q    <= 1'b1;
    end else begin
      rxd_meta_q <= rxd;
      rxd_s_q    <= rxd_meta_q;
    end
  end

  always_comb begin
    eff_prescale = (prescale < PW'(MIN_PRESCALE)) ? PW'(MIN_PRESCALE) : prescale;
    // Good stop bit: the byte is offered to the FIFO on this same edge
    stop_ok      = (state_q == StStop) && (cnt_q == '0) && rxd_s_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      pre_q         <= '0;
      bit_idx_q     <= '0;
      shreg_q       <= '0;
      frame_error_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      frame_error_q <= 1'b0;
      overrun_q     <= 1'b0;
      case (state_q)
        StIdle: begin
          if (!rxd_s_q) begin
            state_q <= StStart;
            pre_q   <= eff_prescale;
            cnt_q   <= (eff_prescale >> 1) - PW'(1);
          end
        end
        StStart: begin
          if (cnt_q == '0) begin
            if (rxd_s_q) begin
              state_q <= StIdle;
            end else begin
              state_q   <= StData;
              cnt_q     <= pre_q - PW'(1);
              bit_idx_q <= '0;
            end
          end else begin
            cnt_q <= cnt_q - PW'(1);
          end
        end
        StData: begin
          if (cnt_q == '0) begin
            shreg_q[bit_idx_q] <= rxd_s_q;
            cnt_q              <= pre_q - PW'(1);
            if (bit_idx_q == IDX_W'(DATA_WIDTH - 1)) begin
              state_q <= StStop;
            end else begin
              bit_idx_q <= bit_idx_q + IDX_W'(1);
            end
          end else begin
            cnt_q <= cnt_q - PW'(1);
          end
        end
        StStop: begin
          if (cnt_q == '0) begin
            if (rxd_s_q) begin
              state_q   <= StIdle;
              overrun_q <= fifo_full && !m_axis_tready;
            end else begin
              state_q       <= StBreak;
              frame_error_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - PW'(1);
          end
        end
        StBreak: begin
          if (rxd_s_q) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  rx_byte_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (stop_ok),
    .data_in  (shreg_q),
    .pop      (m_axis_tready),
    .data_out (m_axis_tdata),
    .level    (fifo_level),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_comb begin
    m_axis_tvalid = !fifo_empty;
    busy          = (state_q != StIdle);
    frame_error   = frame_error_q;
    overrun_error = overrun_q;
  end

endmodule
